// File: rtl/opb_reg_pkg.sv
// Shared register-map offsets, status bit positions and slave FSM states
// for the simulink-to-PPC snapshot register.
package opb_reg_pkg;

  localparam logic [5:0] OFF_DATA   = 6'h00;
  localparam logic [5:0] OFF_STATUS = 6'h01;

  // Positions use the OPB big-endian numbering, where bit 0 is the MSB.
  localparam int STAT_NEW     = 31;
  localparam int STAT_OVR     = 30;
  localparam int STAT_CNT_MSB = 0;
  localparam int STAT_CNT_LSB = 15;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    GAP
  } slv_state_e;

  function automatic logic [0:31] status_word(input logic new_f, input logic ovr_f,
                                              input logic [15:0] cnt);
    logic [0:31] w;
    w = '0;
    w[STAT_CNT_MSB:STAT_CNT_LSB] = cnt;
    w[STAT_OVR] = ovr_f;
    w[STAT_NEW] = new_f;
    return w;
  endfunction

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// OPB address-window decode and single-beat acknowledge sequencer.
// A hit is acked one cycle later, then one dead cycle follows before the next hit is accepted.
//
//   state | meaning
//   IDLE  | waiting for select inside the address window
//   ACK   | Sl_xferAck high, rd_en/wr_en/offset valid for this cycle
//   GAP   | dead cycle, select ignored
module opb_slave_ack_fsm
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h0100_2000,
  parameter logic [31:0] C_HIGHADDR = 32'h0100_20FF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        select,
  input  logic [0:31] abus,
  input  logic        rnw,
  output logic        accept,
  output logic [5:0]  req_offset,
  output logic        xfer_ack,
  output logic        rd_en,
  output logic        wr_en,
  output logic [5:0]  offset
);

  slv_state_e state;
  logic       hit;

  assign hit        = select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
  assign accept     = (state == IDLE) && hit;
  assign req_offset = abus[24:29];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      xfer_ack <= 1'b0;
      rd_en    <= 1'b0;
      wr_en    <= 1'b0;
      offset   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            state    <= ACK;
            xfer_ack <= 1'b1;
            rd_en    <= rnw;
            wr_en    <= !rnw;
            offset   <= req_offset;
          end
        end
        ACK: begin
          state    <= GAP;
          xfer_ack <= 1'b0;
          rd_en    <= 1'b0;
          wr_en    <= 1'b0;
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/opb_register_simulink2ppc_snap.sv
// OPB readback register: captures a user word on a valid strobe and exposes it
// to the PPC together with new-data/overrun flags and a 16-bit update count.
module opb_register_simulink2ppc_snap
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0100_2000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0100_20FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter string       C_FAMILY     = "virtex6"
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  input  logic [31:0]             user_data_in,
  input  logic                    user_data_valid,
  output logic                    user_read_strobe
);

  localparam bit FAMILY_SET = (C_FAMILY != "");

  logic        accept, rd_en, wr_en;
  logic [5:0]  req_offset, offset;
  logic [31:0] snapshot;
  logic        new_f, ovr_f;
  logic [15:0] upd_cnt;
  logic        w1c_new, w1c_ovr;
  logic [0:31] rd_mux;
  logic        data_rd, status_wr;
  logic        unused_inputs;

  assign unused_inputs = ^{OPB_BE, OPB_seqAddr, OPB_DBus[0:29], FAMILY_SET};

  opb_slave_ack_fsm #(
    .C_BASEADDR (C_BASEADDR),
    .C_HIGHADDR (C_HIGHADDR)
  ) u_fsm (
    .clk        (OPB_Clk),
    .rst        (OPB_Rst),
    .select     (OPB_select),
    .abus       (OPB_ABus),
    .rnw        (OPB_RNW),
    .accept     (accept),
    .req_offset (req_offset),
    .xfer_ack   (Sl_xferAck),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .offset     (offset)
  );

  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  assign data_rd   = rd_en && (offset == OFF_DATA);
  assign status_wr = wr_en && (offset == OFF_STATUS);

  always_comb begin
    rd_mux = '0;
    case (req_offset)
      OFF_DATA:   rd_mux = snapshot;
      OFF_STATUS: rd_mux = status_word(new_f, ovr_f, upd_cnt);
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      Sl_DBus          <= '0;
      user_read_strobe <= 1'b0;
      w1c_new          <= 1'b0;
      w1c_ovr          <= 1'b0;
      snapshot         <= '0;
      new_f            <= 1'b0;
      ovr_f            <= 1'b0;
      upd_cnt          <= '0;
    end else begin
      // Read data is frozen at accept so it reflects state in the request cycle.
      Sl_DBus          <= (accept && OPB_RNW) ? rd_mux : '0;
      user_read_strobe <= accept && OPB_RNW && (req_offset == OFF_DATA);
      if (accept) begin
        w1c_new <= OPB_DBus[STAT_NEW];
        w1c_ovr <= OPB_DBus[STAT_OVR];
      end

      // A capture overrides any same-cycle clear of NEW; OVR uses NEW from before the cycle.
      if (user_data_valid) begin
        snapshot <= user_data_in;
        new_f    <= 1'b1;
        upd_cnt  <= upd_cnt + 16'd1;
        if (new_f)
          ovr_f <= 1'b1;
        else if (status_wr && w1c_ovr)
          ovr_f <= 1'b0;
      end else begin
        if (data_rd || (status_wr && w1c_new))
          new_f <= 1'b0;
        if (status_wr && w1c_ovr)
          ovr_f <= 1'b0;
      end
    end
  end

endmodule
